// File: rtl/fir_decim_if.sv
// Sample/coefficient/result bundle for fir_decim; slave = filter side, master = source/sink side.
// Single-cycle valid/ready on samples, strobe-only coefficient writes, pulsed result valid.
interface fir_decim_if #(
   parameter int NB_IN    = 8,
   parameter int NB_COEFF = 8,
   parameter int NB_OUT   = 18,
   parameter int AW       = 5
) ();
   logic                i_valid;
   logic [NB_IN-1:0]    i_is_data;
   logic                o_ready;
   logic                i_coeff_wr;
   logic [AW-1:0]       i_coeff_addr;
   logic [NB_COEFF-1:0] i_coeff_data;
   logic [NB_OUT-1:0]   o_sample;
   logic                o_valid;
   logic                o_sat;

   modport slave (
      input  i_valid, i_is_data, i_coeff_wr, i_coeff_addr, i_coeff_data,
      output o_ready, o_sample, o_valid, o_sat
   );

   modport master (
      output i_valid, i_is_data, i_coeff_wr, i_coeff_addr, i_coeff_data,
      input  o_ready, o_sample, o_valid, o_sat
   );
endinterface

// File: rtl/fir_decim.sv
// Decimating FIR with one multiplier: result FIR_LEN+1 enabled cycles after the starting accept.
// o_ready only in IDLE; samples offered during MAC/OUT stay with the source.
module fir_decim #(
   parameter int FIR_LEN   = 24,
   parameter int DECIM     = 4,
   parameter int NB_COEFF  = 8,
   parameter int NBF_COEFF = 7,
   parameter int NB_IN     = 8,
   parameter int NBF_IN    = 7,
   parameter int NB_OUT    = 18,
   parameter int NBF_OUT   = 17
) (
   input logic       clk,
   input logic       i_reset,
   input logic       i_en,
   fir_decim_if.slave io_bus
);
   localparam int AW      = $clog2(FIR_LEN);
   localparam int PW      = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int NB_PROD = NB_COEFF + NB_IN;
   localparam int NB_ACC  = NB_PROD + $clog2(FIR_LEN);
   localparam int SHIFT   = NBF_OUT - (NBF_COEFF + NBF_IN);
   localparam int NB_SH   = NB_ACC + SHIFT;
   localparam int NB_W    = (NB_SH > NB_OUT) ? NB_SH : NB_OUT;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                     r_state;
   logic signed [NB_IN-1:0]    r_tap   [FIR_LEN];
   logic signed [NB_COEFF-1:0] r_coeff [FIR_LEN];
   logic [PW-1:0]              r_phase;
   logic [AW-1:0]              r_k;
   logic                       r_drain;
   logic signed [NB_ACC-1:0]   r_acc;
   logic [NB_OUT-1:0]          r_sample;
   logic                       r_valid;
   logic                       r_sat;

   logic                       w_accept;
   logic                       w_start;
   logic                       w_coeff_ok;
   logic signed [NB_PROD-1:0]  w_c_ext;
   logic signed [NB_PROD-1:0]  w_t_ext;
   logic signed [NB_PROD-1:0]  w_prod;
   logic signed [NB_W-1:0]     w_wide;
   logic [NB_W-NB_OUT:0]       w_hi;
   logic                       w_ovf;
   logic [NB_OUT-1:0]          w_sat_val;

   assign w_accept   = i_en & io_bus.i_valid & (r_state == IDLE);
   assign w_start    = w_accept & (r_phase == PW'(DECIM - 1));
   assign w_coeff_ok = io_bus.i_coeff_wr & (r_state == IDLE) &
                       (int'(io_bus.i_coeff_addr) < FIR_LEN);

   assign w_c_ext = NB_PROD'(r_coeff[r_k]);
   assign w_t_ext = NB_PROD'(r_tap[r_k]);
   assign w_prod  = w_c_ext * w_t_ext;

   // Align the binary point, then clamp when the bits above the output sign disagree.
   assign w_wide    = NB_W'(r_acc) <<< SHIFT;
   assign w_hi      = w_wide[NB_W-1:NB_OUT-1];
   assign w_ovf     = !((&w_hi) || !(|w_hi));
   assign w_sat_val = w_wide[NB_W-1] ? {1'b1, {(NB_OUT-1){1'b0}}}
                                     : {1'b0, {(NB_OUT-1){1'b1}}};

   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_state  <= IDLE;
         for (int i = 0; i < FIR_LEN; i++) begin
            r_tap[i]   <= '0;
            r_coeff[i] <= '0;
         end
         r_phase  <= '0;
         r_k      <= '0;
         r_drain  <= 1'b0;
         r_acc    <= '0;
         r_sample <= '0;
         r_valid  <= 1'b0;
         r_sat    <= 1'b0;
      end else if (i_en) begin
         if (w_coeff_ok)
            r_coeff[io_bus.i_coeff_addr] <= io_bus.i_coeff_data;
         if (w_accept) begin
            for (int i = FIR_LEN - 1; i > 0; i--)
               r_tap[i] <= r_tap[i-1];
            r_tap[0] <= io_bus.i_is_data;
            r_phase  <= w_start ? '0 : r_phase + PW'(1);
         end
         case (r_state)
            IDLE: begin
               r_valid <= 1'b0;
               if (w_start) begin
                  r_state <= MAC;
                  r_acc   <= '0;
                  r_k     <= '0;
                  r_drain <= 1'b0;
               end
            end
            MAC: begin
               // Extra drain cycle presents the finished sum to the output stage.
               if (r_drain) begin
                  r_sample <= w_ovf ? w_sat_val : w_wide[NB_OUT-1:0];
                  r_sat    <= w_ovf;
                  r_valid  <= 1'b1;
                  r_state  <= OUT;
               end else begin
                  r_acc <= r_acc + NB_ACC'(w_prod);
                  if (r_k == AW'(FIR_LEN - 1))
                     r_drain <= 1'b1;
                  else
                     r_k <= r_k + AW'(1);
               end
            end
            OUT: begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign io_bus.o_ready  = (r_state == IDLE);
   assign io_bus.o_sample = r_sample;
   assign io_bus.o_valid  = r_valid;
   assign io_bus.o_sat    = r_sat;
endmodule

// File: tb/tb_fir_decim.sv
// Directed bench for fir_decim: DECIM=1 and DECIM=4 instances, expected results queued at issue
// and popped by per-instance monitors on each o_valid.
module tb_fir_decim;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, en1, rst4, en4;
   fir_decim_if b1 ();
   fir_decim_if b4 ();

   fir_decim #(.DECIM(1)) u_d1 (.clk(clk), .i_reset(rst1), .i_en(en1), .io_bus(b1));
   fir_decim #(.DECIM(4)) u_d4 (.clk(clk), .i_reset(rst4), .i_en(en4), .io_bus(b4));

   typedef struct {
      logic [17:0] s;
      logic        sat;
      int          due;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];
   exp_t e1, e4;
   int n_cmp  = 0;
   int n_bad  = 0;
   int cyc    = 0;
   int acc4   = 0;
   int pulse4 = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (b4.i_valid && b4.o_ready && en4 && !rst4) acc4 <= acc4 + 1;

   function automatic void chk(string nm, longint act, longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void flag(string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endfunction

   // Expected output for a raw Q14 accumulator value: scale to Q17, clamp to 18 bits.
   function automatic logic [18:0] qout(input longint acc);
      longint v;
      v = acc * 8;
      if (v > 131071)  return {1'b1, 18'h1FFFF};
      if (v < -131072) return {1'b1, 18'h20000};
      return {1'b0, v[17:0]};
   endfunction

   task automatic push1(input logic [18:0] r, input int due);
      q1.push_back('{s: r[17:0], sat: r[18], due: due});
   endtask

   always @(negedge clk) begin
      if (en1 && b1.o_valid) begin
         if (q1.size() == 0) flag("d1_unexpected_valid");
         else begin
            e1 = q1.pop_front();
            chk("d1_sample", b1.o_sample, e1.s);
            chk("d1_sat", b1.o_sat, e1.sat);
            chk("d1_latency", cyc, e1.due);
         end
      end
      if (en4 && b4.o_valid) begin
         pulse4++;
         if (q4.size() == 0) flag("d4_unexpected_valid");
         else begin
            e4 = q4.pop_front();
            chk("d4_sample", b4.o_sample, e4.s);
            chk("d4_sat", b4.o_sat, e4.sat);
            chk("d4_latency", cyc, e4.due);
         end
      end
   end

   task automatic wait_idle1();
      for (int g = 0; g < 200; g++) begin
         if (b1.o_ready) return;
         @(negedge clk);
      end
      flag("d1_idle_timeout");
   endtask

   task automatic wr1(input int a, input logic [7:0] c);
      b1.i_coeff_wr   = 1'b1;
      b1.i_coeff_addr = 5'(a);
      b1.i_coeff_data = c;
      @(negedge clk);
      b1.i_coeff_wr   = 1'b0;
   endtask

   task automatic wr4(input int a, input logic [7:0] c);
      b4.i_coeff_wr   = 1'b1;
      b4.i_coeff_addr = 5'(a);
      b4.i_coeff_data = c;
      @(negedge clk);
      b4.i_coeff_wr   = 1'b0;
   endtask

   // Offers one sample (optionally with a coefficient write in the same cycle); t = cycle before accept edge.
   task automatic send1(input logic [7:0] d, input bit wr, input int a, input logic [7:0] c,
                        output int t);
      t = -1;
      b1.i_is_data = d;
      b1.i_valid   = 1'b1;
      if (wr) begin
         b1.i_coeff_wr   = 1'b1;
         b1.i_coeff_addr = 5'(a);
         b1.i_coeff_data = c;
      end
      for (int g = 0; g < 200; g++) begin
         if (b1.o_ready && en1) begin
            t = cyc;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      b1.i_valid   = 1'b0;
      b1.i_coeff_wr = 1'b0;
      if (t < 0) flag("d1_accept_timeout");
   endtask

   initial begin
      int t;
      int busy;
      rst1 = 1'b1; rst4 = 1'b1; en1 = 1'b1; en4 = 1'b1;
      b1.i_valid = 1'b0; b1.i_is_data = '0; b1.i_coeff_wr = 1'b0; b1.i_coeff_addr = '0; b1.i_coeff_data = '0;
      b4.i_valid = 1'b0; b4.i_is_data = '0; b4.i_coeff_wr = 1'b0; b4.i_coeff_addr = '0; b4.i_coeff_data = '0;
      repeat (3) @(negedge clk);
      rst1 = 1'b0; rst4 = 1'b0;

      chk("d1_rst_ready", b1.o_ready, 1);
      chk("d1_rst_valid", b1.o_valid, 0);
      chk("d1_rst_sample", b1.o_sample, 0);
      chk("d1_rst_sat", b1.o_sat, 0);
      chk("d4_rst_ready", b4.o_ready, 1);
      chk("d4_rst_valid", b4.o_valid, 0);
      chk("d4_rst_sample", b4.o_sample, 0);
      chk("d4_rst_sat", b4.o_sat, 0);

      // Single-tap product 0.5 * 0.5.
      wr1(0, 8'h40);
      send1(8'h40, 1'b0, 0, 8'h00, t); push1({1'b0, 18'h08000}, t + 26); wait_idle1();

      // Write to coeff[1] while busy must not land.
      send1(8'h20, 1'b0, 0, 8'h00, t); push1({1'b0, 18'h04000}, t + 26);
      wr1(1, 8'h7F);
      wait_idle1();
      send1(8'h10, 1'b0, 0, 8'h00, t); push1({1'b0, 18'h02000}, t + 26); wait_idle1();

      // Same write in IDLE applies.
      wr1(1, 8'h7F);
      send1(8'h08, 1'b0, 0, 8'h00, t); push1({1'b0, 18'h04F80}, t + 26); wait_idle1();

      // Write coeff[2] in the accepting cycle; the computation sees it.
      send1(8'h00, 1'b1, 2, 8'h01, t); push1({1'b0, 18'h02040}, t + 26); wait_idle1();

      // Reset mid-MAC: no result, outputs cleared.
      send1(8'h40, 1'b0, 0, 8'h00, t);
      repeat (10) @(negedge clk);
      rst1 = 1'b1;
      @(negedge clk);
      rst1 = 1'b0;
      chk("d1_midrst_ready", b1.o_ready, 1);
      chk("d1_midrst_valid", b1.o_valid, 0);
      chk("d1_midrst_sample", b1.o_sample, 0);
      chk("d1_midrst_sat", b1.o_sat, 0);
      repeat (40) @(negedge clk);

      // Enable dropped for 5 cycles mid-MAC: same result, 5 cycles later.
      wr1(0, 8'h40);
      send1(8'h40, 1'b0, 0, 8'h00, t); push1({1'b0, 18'h08000}, t + 31);
      repeat (10) @(negedge clk);
      en1 = 1'b0;
      repeat (5) @(negedge clk);
      en1 = 1'b1;
      wait_idle1();

      // Full-scale sums: positive clamp, then through zero to negative clamp.
      rst1 = 1'b1;
      @(negedge clk);
      rst1 = 1'b0;
      for (int k = 0; k < 24; k++) wr1(k, 8'h7F);
      for (int n = 1; n <= 24; n++) begin
         send1(8'h7F, 1'b0, 0, 8'h00, t);
         push1(qout(longint'(n) * 16129), t + 26);
         wait_idle1();
      end
      for (int m = 1; m <= 24; m++) begin
         send1(8'h80, 1'b0, 0, 8'h00, t);
         push1(qout(127 * (127 * longint'(24 - m) - 128 * longint'(m))), t + 26);
         wait_idle1();
      end

      // DECIM=4 impulse with valid held high for 16 samples, coeff[k] = k+1.
      for (int k = 0; k < 24; k++) wr4(k, 8'(k + 1));
      b4.i_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         b4.i_is_data = (i == 0) ? 8'h10 : 8'h00;
         t = -1;
         for (int g = 0; g < 100; g++) begin
            if (b4.o_ready) begin
               t = cyc;
               break;
            end
            @(negedge clk);
         end
         if (t < 0) flag("d4_accept_timeout");
         @(negedge clk);
         if (i % 4 == 3) begin
            q4.push_back('{s: 18'(512 * ((i + 1) / 4)), sat: 1'b0, due: t + 26});
            busy = 0;
            for (int g = 0; g < 26; g++) begin
               busy += int'(b4.o_ready);
               @(negedge clk);
            end
            chk("d4_ready_low_busy", busy, 0);
            chk("d4_ready_back", b4.o_ready, 1);
         end
      end
      b4.i_valid = 1'b0;

      repeat (40) @(negedge clk);
      chk("d1_queue_empty", q1.size(), 0);
      chk("d4_queue_empty", q4.size(), 0);
      chk("d4_accept_count", acc4, 16);
      chk("d4_pulse_count", pulse4, 4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fir_decim.md
FIR_DECIM -- requirements
Module: fir_decim

Interface
REQ-001 FIR_LEN, 24, number of taps (>=2).
REQ-002 DECIM, 4, decimation factor (>=1; 1 = no decimation).
REQ-003 NB_COEFF / NBF_COEFF, 8 / 7, coefficient width / fractional bits, signed.
REQ-004 NB_IN / NBF_IN, 8 / 7, input sample width / fractional bits, signed.
REQ-005 NB_OUT / NBF_OUT, 18 / 17, output width / fractional bits, signed; NBF_OUT >= NBF_COEFF+NBF_IN.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 i_reset  in  1  synchronous, active-high reset.
REQ-008 i_en  in  1  global enable; 0 freezes every register.
REQ-009 i_valid  in  1  input sample valid.
REQ-010 i_is_data  in  NB_IN  input sample, signed.
REQ-011 o_ready  out  1  block accepts a sample this cycle.
REQ-012 i_coeff_wr  in  1  coefficient write strobe.
REQ-013 i_coeff_addr  in  clog2(FIR_LEN)  tap index; 0 = newest sample.
REQ-014 i_coeff_data  in  NB_COEFF  coefficient value, signed.
REQ-015 o_sample  out  NB_OUT  filtered, decimated, saturated output.
REQ-016 o_valid  out  1  o_sample is new, one-cycle pulse.
REQ-017 o_sat  out  1  saturation occurred on the current o_sample.

Function
REQ-018 Accept = i_en & i_valid & o_ready; on accept, delay line shifts (tap[k]<=tap[k-1]) and tap[0]<=i_is_data.
REQ-019 Phase counter counts accepts 0..DECIM-1, wraps to 0; accept at phase DECIM-1 starts a computation.
REQ-020 FSM states IDLE, MAC, OUT; IDLE->MAC on starting accept; MAC->OUT after FIR_LEN MAC cycles; OUT->IDLE after one cycle.
REQ-021 o_ready = 1 only in IDLE; samples presented in MAC/OUT are not consumed and must be held by source.
REQ-022 Single multiplier: MAC cycle k (0..FIR_LEN-1) adds coeff[k]*tap[k] to accumulator; accumulator cleared on entry to MAC.
REQ-023 Accumulator width NB_COEFF+NB_IN+clog2(FIR_LEN); no internal overflow possible.
REQ-024 Output alignment: accumulator shifted left by NBF_OUT-(NBF_COEFF+NBF_IN), then saturated to NB_OUT: max 0 followed by ones, min 1 followed by zeros.
REQ-025 o_sample, o_sat registered on MAC->OUT transition; o_valid high exactly during OUT; o_sample held until next OUT.
REQ-026 Latency: o_valid asserted FIR_LEN+1 enabled cycles after the edge that accepts the starting sample.
REQ-027 Coefficient write takes effect at next edge only when i_en=1 and state is IDLE; writes in MAC/OUT are ignored; address >= FIR_LEN ignored.
REQ-028 i_en=0 holds all state incl. o_valid; consumers qualify o_valid with i_en.
REQ-029 Accept in same cycle as coefficient write: both take effect; computation uses new coefficient.

Reset
REQ-030 i_reset=1 at a clock edge: delay line, accumulator, phase counter to 0, FSM to IDLE, o_sample=0, o_valid=0, o_sat=0, o_ready=1 next cycle; overrides i_en.
REQ-031 Coefficients reset to 0; reset mid-MAC aborts computation with no o_valid.

Verification
REQ-032 DECIM=1, coeff[0]=8'h40, others 0, input 8'h40 -> o_valid 25 cycles after accept, o_sample=18'h08000, o_sat=0.
REQ-033 DECIM=1, all coeff 8'h7F, 24 samples of 8'h7F -> final o_sample=18'h1FFFF, o_sat=1; with input 8'h80 -> 18'h20000, o_sat=1.
REQ-034 DECIM=4, i_valid held high 16 samples, impulse response check -> exactly 4 o_valid pulses, o_ready low during each MAC/OUT, no sample lost or duplicated.
REQ-035 Coefficient write during MAC -> ignored (output unchanged vs reference model); same write in IDLE -> applied.
REQ-036 i_reset pulsed mid-MAC -> no o_valid, all outputs 0, o_ready=1 next cycle; i_en=0 for 5 cycles mid-MAC -> result identical, latency +5.
